sra_seq_shifter: RTL and testbench

SRA_SEQ_SHIFTER -- requirements
Module: sra_seq_shifter

---
 rtl/sra_pkg.sv | 18 +
 rtl/sra_seq_shifter.sv | 99 +++++++++
 tb/tb_sra_seq_shifter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sra_pkg.sv
// ----------------------------------------------------------------------------
// sra_pkg
// Shared definitions for the sequential arithmetic right shifter.
//   SRA_WIDTH / SRA_AMTW : default data width and shift-amount width
//   ST_IDLE / ST_SHIFT / ST_DONE : FSM state encodings
// ----------------------------------------------------------------------------
package sra_pkg;

    localparam int SRA_WIDTH = 8;
    localparam int SRA_AMTW  = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/sra_seq_shifter.sv
// ----------------------------------------------------------------------------
// sra_seq_shifter
// Arithmetic right shift, one bit per clock, with a sticky flag that records
// whether any 1 bit was shifted out. One operand is in flight at a time.
//
// Ports
//   clk        : clock, rising-edge active
//   rst        : asynchronous active-high reset
//   in_valid   : operand offered by upstream
//   in_ready   : block can accept an operand (IDLE only)
//   in_data    : signed operand, WIDTH bits
//   in_amt     : unsigned shift amount, AMTW bits
//   out_valid  : result held for downstream (DONE only)
//   out_ready  : downstream takes the result
//   out_data   : shifted result, straight from the working register
//   out_sticky : OR of all bits shifted out
//   busy       : high whenever the FSM is not in IDLE
// ----------------------------------------------------------------------------
module sra_seq_shifter
    import sra_pkg::*;
#(
    parameter int WIDTH = SRA_WIDTH,
    parameter int AMTW  = SRA_AMTW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMTW-1:0]  in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [AMTW-1:0]  cnt;
    logic             sticky;

    // Held low by reset and set on the first clock edge afterwards, so that
    // in_ready stays low while reset is active and rises one edge later.
    logic             armed;

    // FSM, counter and shift register share one process so that the shift,
    // sticky update and counter decrement always move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            work   <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        work   <= in_data;
                        cnt    <= in_amt;
                        sticky <= 1'b0;
                        state  <= (in_amt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The nonzero guard keeps the counter from wrapping; a
                    // zero count here can only mean corruption, so finish.
                    if (cnt != '0) begin
                        work   <= {work[WIDTH-1], work[WIDTH-1:1]};
                        sticky <= sticky | work[0];
                        cnt    <= cnt - AMTW'(1);
                        if (cnt == AMTW'(1)) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = armed && (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);
    assign out_data   = work;
    assign out_sticky = sticky;

endmodule

// File: tb/tb_sra_seq_shifter.sv
// ----------------------------------------------------------------------------
// tb_sra_seq_shifter
// Self-checking bench for sra_seq_shifter: directed operands with literal
// expectations, a hold/back-pressure case, an asynchronous reset mid-shift,
// and a randomized phase, all compared each cycle against a timestamp model.
// ----------------------------------------------------------------------------
module tb_sra_seq_shifter;

    localparam int WIDTH = 8;
    localparam int AMTW  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMTW-1:0]  in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sticky;
    logic             busy;

    int errors = 0;
    int checks = 0;

    sra_seq_shifter #(.WIDTH(WIDTH), .AMTW(AMTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Transaction model: an operand accepted at edge number a presents its
    // result from edge a+amt onward, until an edge where out_ready is high.
    int               cyc       = 0;
    int               m_done_at = 0;
    logic             m_armed   = 1'b0;
    logic             m_active  = 1'b0;
    logic [WIDTH-1:0] m_data    = '0;
    logic             m_sticky  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_armed  <= 1'b0;
            m_active <= 1'b0;
        end else begin
            cyc     <= cyc + 1;
            m_armed <= 1'b1;
            if (m_active) begin
                if (cyc > m_done_at && out_ready) begin
                    m_active <= 1'b0;
                end
            end else if (m_armed && in_valid) begin
                m_active  <= 1'b1;
                m_done_at <= cyc + int'(in_amt);
                m_data    <= WIDTH'($signed(in_data) >>> in_amt);
                m_sticky  <= ((int'(in_data) & ((1 << in_amt) - 1)) != 0);
            end
        end
    end

    logic exp_valid;
    logic exp_ready;
    assign exp_valid = m_active && (cyc > m_done_at);
    assign exp_ready = m_armed && !m_active;

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        checkOutput("cyc out_valid", 32'(out_valid), 32'(exp_valid));
        checkOutput("cyc in_ready", 32'(in_ready), 32'(exp_ready));
        checkOutput("cyc busy", 32'(busy), 32'(m_active));
        if (rst) begin
            checkOutput("rst out_data", 32'(out_data), 32'h0);
            checkOutput("rst out_sticky", 32'(out_sticky), 32'h0);
        end else if (exp_valid) begin
            checkOutput("cyc out_data", 32'(out_data), 32'(m_data));
            checkOutput("cyc out_sticky", 32'(out_sticky), 32'(m_sticky));
        end
    end

    // Offers one operand, measures cycles from the accepting edge (counted as
    // 1) to the first cycle out_valid is seen, optionally holds the result
    // with out_ready low while pushing an operand that must be ignored, then
    // releases it and confirms in_ready returns on the next cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic [AMTW-1:0] amt,
                                 input int hold, output logic [WIDTH-1:0] got_data,
                                 output logic got_sticky, output int lat);
        int  n;
        logic [WIDTH-1:0] held;
        got_data   = '0;
        got_sticky = 1'b0;
        lat        = 0;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("timeout in_ready", 32'(in_ready), 32'h1);
            return;
        end
        in_valid = 1'b1;
        in_data  = data;
        in_amt   = amt;
        @(posedge clk);
        #2 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) begin
            checkOutput("timeout out_valid", 32'(out_valid), 32'h1);
            return;
        end
        got_data   = out_data;
        got_sticky = out_sticky;
        held       = out_data;
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data  = 8'h11;
            in_amt   = 3'd0;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold out_valid", 32'(out_valid), 32'h1);
            checkOutput("hold out_data", 32'(out_data), 32'(held));
            checkOutput("hold in_ready", 32'(in_ready), 32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("release in_ready", 32'(in_ready), 32'h1);
    endtask

    logic [WIDTH-1:0] got_d;
    logic             got_s;
    int               got_lat;
    int               seen_valid;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'h0);
        checkOutput("reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        #2 rst = 1'b0;
        #1 checkOutput("post-rst in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1 checkOutput("first-edge in_ready", 32'(in_ready), 32'h1);

        applyStimulus(8'hA4, 3'd2, 0, got_d, got_s, got_lat);
        checkOutput("A4>>2 data", 32'(got_d), 32'hE9);
        checkOutput("A4>>2 sticky", 32'(got_s), 32'h0);
        checkOutput("A4>>2 latency", 32'(got_lat), 32'd3);
        checkOutput("model A4>>2", 32'(m_data), 32'hE9);

        applyStimulus(8'h7F, 3'd3, 0, got_d, got_s, got_lat);
        checkOutput("7F>>3 data", 32'(got_d), 32'h0F);
        checkOutput("7F>>3 sticky", 32'(got_s), 32'h1);
        checkOutput("7F>>3 latency", 32'(got_lat), 32'd4);
        checkOutput("model 7F>>3 sticky", 32'(m_sticky), 32'h1);

        applyStimulus(8'h80, 3'd7, 0, got_d, got_s, got_lat);
        checkOutput("80>>7 data", 32'(got_d), 32'hFF);
        checkOutput("80>>7 sticky", 32'(got_s), 32'h0);
        checkOutput("80>>7 latency", 32'(got_lat), 32'd8);
        checkOutput("model 80>>7", 32'(m_data), 32'hFF);

        applyStimulus(8'h55, 3'd0, 0, got_d, got_s, got_lat);
        checkOutput("55>>0 data", 32'(got_d), 32'h55);
        checkOutput("55>>0 sticky", 32'(got_s), 32'h0);
        checkOutput("55>>0 latency", 32'(got_lat), 32'd1);

        applyStimulus(8'hC3, 3'd1, 5, got_d, got_s, got_lat);
        checkOutput("C3>>1 data", 32'(got_d), 32'hE1);
        checkOutput("C3>>1 sticky", 32'(got_s), 32'h1);
        repeat (4) @(negedge clk);
        checkOutput("ignored op no busy", 32'(busy), 32'h0);

        // Reset three shifts into a long operation.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA4;
        in_amt   = 3'd7;
        @(posedge clk);
        #2 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("async rst in_ready", 32'(in_ready), 32'h0);
        checkOutput("async rst out_valid", 32'(out_valid), 32'h0);
        checkOutput("async rst busy", 32'(busy), 32'h0);
        checkOutput("async rst out_data", 32'(out_data), 32'h0);
        checkOutput("async rst out_sticky", 32'(out_sticky), 32'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        seen_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        checkOutput("no valid after rst", 32'(seen_valid), 32'h0);

        applyStimulus(8'hA4, 3'd7, 0, got_d, got_s, got_lat);
        checkOutput("A4>>7 data", 32'(got_d), 32'hFF);
        checkOutput("A4>>7 sticky", 32'(got_s), 32'h1);
        checkOutput("A4>>7 latency", 32'(got_lat), 32'd8);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #2;
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            in_amt    = 3'($urandom);
            out_ready = 1'($urandom);
        end
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("drained busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
